// File: rtl/uart_baud_gen.sv
// Fractional-N baud generator: oversample tick plus baud tick every OVERSAMPLE-th
// oversample tick, with divisor-change detection, count enable and mid-bit resync.
module uart_baud_gen #(
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4,
  parameter int OVERSAMPLE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              resync,
  output logic              tick_os,
  output logic              tick_baud,
  output logic              div_changed
);

  localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2);

  logic [DIV_W-1:0]  sh_int_reg,  sh_int_next;
  logic [FRAC_W-1:0] sh_frac_reg, sh_frac_next;
  logic [DIV_W-1:0]  cnt_reg,     cnt_next;
  logic [FRAC_W-1:0] acc_reg,     acc_next;
  logic [OS_W-1:0]   os_cnt_reg,  os_cnt_next;
  logic              div_changed_reg, div_changed_next;

  logic              active;
  logic              cnt_zero;
  logic              div_diff;
  logic [FRAC_W:0]   acc_sum;
  logic [DIV_W-1:0]  reload_in;
  logic [DIV_W-1:0]  reload_sh;

  assign active    = (sh_int_reg != '0);
  assign cnt_zero  = (cnt_reg == '0);
  assign div_diff  = ({div_int, div_frac} != {sh_int_reg, sh_frac_reg});
  assign acc_sum   = {1'b0, acc_reg} + {1'b0, sh_frac_reg};
  assign reload_in = (div_int == '0) ? '0 : div_int - DIV_W'(1);
  assign reload_sh = (sh_int_reg == '0) ? '0 : sh_int_reg - DIV_W'(1);

  assign tick_os     = !rst && en && active && cnt_zero;
  assign tick_baud   = tick_os && (os_cnt_reg == OS_LAST);
  assign div_changed = div_changed_reg;

  always_comb begin
    sh_int_next      = sh_int_reg;
    sh_frac_next     = sh_frac_reg;
    cnt_next         = cnt_reg;
    acc_next         = acc_reg;
    os_cnt_next      = os_cnt_reg;
    div_changed_next = 1'b0;
    if (div_diff) begin
      // A new divisor always wins: restart phase cleanly from the new value.
      sh_int_next      = div_int;
      sh_frac_next     = div_frac;
      cnt_next         = reload_in;
      acc_next         = '0;
      os_cnt_next      = '0;
      div_changed_next = 1'b1;
    end else if (resync) begin
      cnt_next    = reload_sh;
      acc_next    = '0;
      os_cnt_next = OS_HALF;
    end else if (en && active) begin
      if (cnt_zero) begin
        // Fractional carry stretches the following interval by one cycle.
        acc_next    = acc_sum[FRAC_W-1:0];
        cnt_next    = sh_int_reg - DIV_W'(1) + DIV_W'(acc_sum[FRAC_W]);
        os_cnt_next = (os_cnt_reg == OS_LAST) ? '0 : os_cnt_reg + OS_W'(1);
      end else begin
        cnt_next = cnt_reg - DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_int_reg      <= div_int;
      sh_frac_reg     <= div_frac;
      cnt_reg         <= reload_in;
      acc_reg         <= '0;
      os_cnt_reg      <= '0;
      div_changed_reg <= 1'b0;
    end else begin
      sh_int_reg      <= sh_int_next;
      sh_frac_reg     <= sh_frac_next;
      cnt_reg         <= cnt_next;
      acc_reg         <= acc_next;
      os_cnt_reg      <= os_cnt_next;
      div_changed_reg <= div_changed_next;
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: closed-form tick model checked every cycle, directed
// scenarios with literal expectations, then randomized enable/resync/divisor/reset.
module tb_uart_baud_gen;

  localparam int DIV_W      = 16;
  localparam int FRAC_W     = 4;
  localparam int OVERSAMPLE = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              resync;
  logic              tick_os;
  logic              tick_baud;
  logic              div_changed;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  uart_baud_gen #(
    .DIV_W(DIV_W),
    .FRAC_W(FRAC_W),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .div_int(div_int),
    .div_frac(div_frac),
    .resync(resync),
    .tick_os(tick_os),
    .tick_baud(tick_baud),
    .div_changed(div_changed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference model: the interval after the k-th tick since a reload is
  // D plus the change in floor(k*F / 2^FRAC_W); baud is every OVERSAMPLE-th tick
  // counted from a start offset (0 after reload, OVERSAMPLE/2 after resync).
  int m_d, m_f, m_left, m_k, m_base;
  bit m_dc, m_valid = 1'b0;
  bit e_os, e_baud;

  function automatic int carry_at(input int k, input int f);
    return ((k * f) >> FRAC_W) - (((k - 1) * f) >> FRAC_W);
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        e_os   = !rst && en && (m_d != 0) && (m_left == 1);
        e_baud = e_os && (((m_base + m_k) % OVERSAMPLE) == OVERSAMPLE - 1);
        check("tick_os", tick_os, e_os);
        check("tick_baud", tick_baud, e_baud);
        check("div_changed", div_changed, m_dc);
      end
      if (rst || int'(div_int) != m_d || int'(div_frac) != m_f) begin
        m_dc    = !rst;
        m_d     = int'(div_int);
        m_f     = int'(div_frac);
        m_left  = m_d;
        m_k     = 0;
        m_base  = 0;
        m_valid = 1'b1;
      end else if (resync) begin
        m_dc   = 1'b0;
        m_left = m_d;
        m_k    = 0;
        m_base = OVERSAMPLE / 2;
      end else begin
        m_dc = 1'b0;
        if (en && m_d != 0) begin
          if (m_left == 1) begin
            m_k++;
            m_left = m_d + carry_at(m_k, m_f);
          end else begin
            m_left--;
          end
        end
      end
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_div(input int d, input int f);
    div_int  = DIV_W'(d);
    div_frac = FRAC_W'(f);
  endtask

  // Walks negedges until the first tick_os (or tick_baud), recording absolute cycles.
  task automatic measure(input int max_cyc, input bit want_baud, output int t_os,
                         output int t_baud, output int n_os, output bit dc_first);
    t_os = -1; t_baud = -1; n_os = 0; dc_first = 1'b0;
    for (int n = 0; n < max_cyc; n++) begin
      @(negedge clk);
      if (n == 0) dc_first = div_changed;
      if (tick_os) begin
        n_os++;
        if (t_os < 0) t_os = cyc;
      end
      if (tick_baud && t_baud < 0) t_baud = cyc;
      if (want_baud ? (t_baud >= 0) : (t_os >= 0)) return;
    end
    checks++;
    failures++;
    $display("FAIL measure_timeout: no tick within %0d cycles (cycle %0d)", max_cyc, cyc);
  endtask

  int c0, t_os, t_baud, n_os, t1, span, cnt;
  bit dcf;
  int t[32];
  int iv[7] = '{4, 4, 5, 4, 5, 4, 5};

  initial begin
    rst = 1'b1; en = 1'b1; resync = 1'b0;
    set_div(4, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tick_os", tick_os, 0);
    check("reset_div_changed", div_changed, 0);

    // Reset release, D=4: ticks at cycles 3,7,..; 16th tick (baud) at cycle 63.
    @(posedge clk); #1;
    rst = 1'b0;
    c0 = cyc;
    measure(200, 1'b1, t_os, t_baud, n_os, dcf);
    check("reset_first_os", t_os - c0, 3);
    check("reset_first_baud", t_baud - c0, 63);
    check("reset_os_count", n_os, 16);

    // Fractional D=4, F=8: intervals 4,4,5,4,5,...
    drive_edge();
    set_div(4, 8);
    drive_edge();
    c0 = cyc;
    for (int i = 0; i < 32; i++) begin
      measure(20, 1'b0, t_os, t_baud, n_os, dcf);
      if (i == 0) check("frac_div_changed", dcf, 1);
      t[i] = t_os;
    end
    check("frac_interval0", t[0] - c0 + 1, iv[0]);
    for (int i = 1; i < 7; i++) check($sformatf("frac_interval%0d", i), t[i] - t[i-1], iv[i]);
    span = t[31] - c0 + 1;
    check("frac_span32_near_144", (span >= 143 && span <= 145), 1);

    // Mid-period change to D=10: first tick 10 cycles, baud 160 cycles after reload.
    drive_edge();
    drive_edge();
    set_div(10, 0);
    drive_edge();
    c0 = cyc;
    measure(300, 1'b1, t_os, t_baud, n_os, dcf);
    check("chg_div_changed", dcf, 1);
    check("chg_first_os", t_os - c0 + 1, 10);
    check("chg_first_baud", t_baud - c0 + 1, 160);

    // D=8 with en low for 7 cycles mid-period: interval stretches to 15.
    drive_edge();
    set_div(8, 0);
    measure(50, 1'b0, t_os, t_baud, n_os, dcf);
    t1 = t_os;
    repeat (3) drive_edge();
    en = 1'b0;
    repeat (7) drive_edge();
    en = 1'b1;
    measure(50, 1'b0, t_os, t_baud, n_os, dcf);
    check("hold_interval", t_os - t1, 15);

    // Resync, D=2: baud after 8 oversample ticks, 16 cycles.
    drive_edge();
    set_div(2, 0);
    measure(20, 1'b0, t_os, t_baud, n_os, dcf);
    drive_edge();
    resync = 1'b1;
    drive_edge();
    c0 = cyc;
    resync = 1'b0;
    measure(100, 1'b1, t_os, t_baud, n_os, dcf);
    check("resync_baud_cycles", t_baud - c0 + 1, 16);
    check("resync_os_count", n_os, 8);

    // Resync together with a divisor change: the change wins (full 16 ticks to baud).
    drive_edge();
    resync = 1'b1;
    set_div(3, 0);
    drive_edge();
    c0 = cyc;
    resync = 1'b0;
    measure(200, 1'b1, t_os, t_baud, n_os, dcf);
    check("resync_chg_div_changed", dcf, 1);
    check("resync_chg_baud_cycles", t_baud - c0 + 1, 48);
    check("resync_chg_os_count", n_os, 16);

    // D=0 stops the generator; D=1 ticks every cycle.
    drive_edge();
    set_div(0, 0);
    drive_edge();
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) check("d0_div_changed", div_changed, 1);
      if (tick_os || tick_baud) cnt++;
    end
    check("d0_tick_count", cnt, 0);
    drive_edge();
    set_div(1, 0);
    drive_edge();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tick_os) cnt++;
    end
    check("d1_tick_count", cnt, 20);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      drive_edge();
      rst    = ($urandom % 300) == 0;
      en     = ($urandom % 8) != 0;
      resync = ($urandom % 50) == 0;
      if (($urandom % 120) == 0) set_div(int'($urandom_range(0, 6)), int'($urandom_range(0, 15)));
    end
    drive_edge();
    rst = 1'b0; en = 1'b1; resync = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
